host_cmd_deframer: RTL and testbench

HOST_CMD_DEFRAMER -- requirements
Module: host_cmd_deframer

---
 rtl/host_cmd_deframer_pkg.sv | 33 +++
 rtl/host_cmd_deframer.sv | 169 ++++++++++++++++
 tb/tb_host_cmd_deframer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_cmd_deframer_pkg.sv
// rtl/host_cmd_deframer_pkg.sv - shared frame field widths, parser states and command codes
package host_cmd_deframer_pkg;

    localparam int WORD_W = 16;
    localparam int DEST_W = 8;
    localparam int CMD_W  = 8;
    localparam int LEN_W  = 24;
    localparam int CSUM_W = 32;

    typedef enum logic [2:0] {
        S_DEST,
        S_CMD,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM_HI,
        S_CSUM_LO
    } state_e;

    // Host command codes; the deframer passes cmd through without decoding it.
    localparam logic [CMD_W-1:0] CMD_NOP    = 8'h00;
    localparam logic [CMD_W-1:0] CMD_READ   = 8'h10;
    localparam logic [CMD_W-1:0] CMD_WRITE  = 8'h20;
    localparam logic [CMD_W-1:0] CMD_ERASE  = 8'h30;
    localparam logic [CMD_W-1:0] CMD_STATUS = 8'h40;

    // Running payload checksum: plain 32-bit sum of zero-extended words.
    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [WORD_W-1:0] w);
        return acc + {{(CSUM_W-WORD_W){1'b0}}, w};
    endfunction

endpackage

// File: rtl/host_cmd_deframer.sv
// rtl/host_cmd_deframer.sv - host word stream to header + payload stream deframer with checksum and idle timeout
module host_cmd_deframer
    import host_cmd_deframer_pkg::*;
#(
    parameter int host_width     = 16,
    parameter int timeout_cycles = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [host_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DEST_W-1:0]     dest,
    output logic [CMD_W-1:0]      cmd,
    output logic [LEN_W-1:0]      length,
    output logic                  hdr_valid,
    output logic [host_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  csum_ok,
    output logic                  timeout_err
);

    localparam int TO_W = $clog2(timeout_cycles + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(timeout_cycles);

    state_e                state_q, state_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic [DEST_W-1:0]     dest_q;
    logic [CMD_W-1:0]      cmd_q;
    logic [LEN_W-1:0]      length_q;
    logic [LEN_W-1:0]      cnt_q;
    logic [CSUM_W-1:0]     acc_q;
    logic [WORD_W-1:0]     csum_hi_q;
    logic                  hdr_valid_q;
    logic                  frame_done_q;
    logic                  csum_ok_q;
    logic                  timeout_err_q;
    logic [host_width-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;

    logic                  in_rdy;
    logic                  xfer;
    logic                  abort;
    logic                  last_word;

    // Next-state, handshake and idle-timeout decisions for the frame parser.
    always_comb begin
        state_d   = state_q;
        in_rdy    = 1'b1;
        to_d      = '0;
        abort     = 1'b0;
        if (state_q == S_DATA) begin
            in_rdy = !out_valid_q || out_ready;
        end
        xfer      = in_valid && in_rdy;
        last_word = ((cnt_q + LEN_W'(1)) == length_q);
        if (state_q != S_DEST && !xfer) begin
            to_d = to_q + TO_W'(1);
            if (to_d == TO_LIMIT) begin
                abort = 1'b1;
                to_d  = '0;
            end
        end
        if (abort) begin
            state_d = S_DEST;
        end else if (xfer) begin
            case (state_q)
                S_DEST:    state_d = S_CMD;
                S_CMD:     state_d = S_LEN_HI;
                S_LEN_HI:  state_d = S_LEN_LO;
                S_LEN_LO:  state_d = ({length_q[LEN_W-1:16], in_data} != '0) ? S_DATA : S_CSUM_HI;
                S_DATA:    state_d = last_word ? S_CSUM_HI : S_DATA;
                S_CSUM_HI: state_d = S_CSUM_LO;
                S_CSUM_LO: state_d = S_DEST;
                default:   state_d = S_DEST;
            endcase
        end
    end

    // Parser state and idle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_DEST;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
        end
    end

    // Header fields, payload counter, checksum accumulator and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q        <= '0;
            cmd_q         <= '0;
            length_q      <= '0;
            cnt_q         <= '0;
            acc_q         <= '0;
            csum_hi_q     <= '0;
            hdr_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            csum_ok_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            hdr_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            csum_ok_q     <= 1'b0;
            timeout_err_q <= abort;
            if (xfer) begin
                case (state_q)
                    S_DEST: begin
                        dest_q <= in_data[DEST_W-1:0];
                        acc_q  <= '0;
                        cnt_q  <= '0;
                    end
                    S_CMD:    cmd_q <= in_data[CMD_W-1:0];
                    S_LEN_HI: length_q[LEN_W-1:16] <= in_data[7:0];
                    S_LEN_LO: begin
                        length_q[15:0] <= in_data;
                        hdr_valid_q    <= 1'b1;
                    end
                    S_DATA: begin
                        acc_q <= csum_add(acc_q, in_data);
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                    S_CSUM_HI: csum_hi_q <= in_data;
                    S_CSUM_LO: begin
                        frame_done_q <= 1'b1;
                        csum_ok_q    <= ({csum_hi_q, in_data} == acc_q);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Single-entry payload register; an aborted frame still drains what it holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (xfer && state_q == S_DATA) begin
            out_data_q  <= in_data;
            out_valid_q <= 1'b1;
            out_last_q  <= last_word;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign in_ready    = in_rdy;
    assign dest        = dest_q;
    assign cmd         = cmd_q;
    assign length      = length_q;
    assign hdr_valid   = hdr_valid_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign frame_done  = frame_done_q;
    assign csum_ok     = csum_ok_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_host_cmd_deframer.sv
// tb/tb_host_cmd_deframer.sv - randomized self-checking bench for host_cmd_deframer
module tb_host_cmd_deframer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  dest;
    logic [7:0]  cmd;
    logic [23:0] length;
    logic        hdr_valid;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        frame_done;
    logic        csum_ok;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc_cyc = 0;

    logic [39:0] exp_hdr[$];
    logic [16:0] exp_dat[$];
    logic        exp_done[$];
    int          exp_tmo = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    host_cmd_deframer #(.host_width(16), .timeout_cycles(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .dest(dest), .cmd(cmd), .length(length), .hdr_valid(hdr_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_done(frame_done), .csum_ok(csum_ok), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string p);
        check({p, "_dest"}, dest, 0);
        check({p, "_cmd"}, cmd, 0);
        check({p, "_length"}, length, 0);
        check({p, "_hdr_valid"}, hdr_valid, 0);
        check({p, "_out_valid"}, out_valid, 0);
        check({p, "_out_data"}, out_data, 0);
        check({p, "_out_last"}, out_last, 0);
        check({p, "_frame_done"}, frame_done, 0);
        check({p, "_csum_ok"}, csum_ok, 0);
        check({p, "_timeout_err"}, timeout_err, 0);
        check({p, "_in_ready"}, in_ready, 1);
    endtask

    // Reference: read the frame fields straight from the word list.
    task automatic model_frame(input logic [15:0] w[$]);
        int          len;
        logic [31:0] sum;
        len = int'({w[2][7:0], w[3]});
        exp_hdr.push_back({w[0][7:0], w[1][7:0], w[2][7:0], w[3]});
        sum = 0;
        for (int i = 0; i < len; i++) begin
            sum = sum + {16'h0, w[4+i]};
            exp_dat.push_back({(i == len - 1), w[4+i]});
        end
        exp_done.push_back({w[4+len], w[5+len]} == sum);
    endtask

    task automatic make_frame(input logic [15:0] d, input logic [15:0] c, input int len,
                              input bit alt80, input bit bad, output logic [15:0] w[$]);
        logic [31:0] sum;
        logic [23:0] l;
        logic [15:0] p;
        l = 24'(len);
        w = {};
        w.push_back(d);
        w.push_back(c);
        w.push_back({8'($urandom), l[23:16]});
        w.push_back(l[15:0]);
        sum = 0;
        for (int i = 0; i < len; i++) begin
            if (alt80) p = (i % 2 == 0) ? 16'h0080 : 16'h0000;
            else       p = 16'($urandom);
            sum = sum + {16'h0, p};
            w.push_back(p);
        end
        if (bad) sum = sum ^ (32'd1 << $urandom_range(0, 31));
        w.push_back(sum[31:16]);
        w.push_back(sum[15:0]);
    endtask

    // Entered at a negedge; returns at the negedge after the word is taken.
    task automatic send_word(input logic [15:0] w, input int gap);
        int guard;
        repeat (gap) @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        guard    = 0;
        forever begin
            #4;
            if (in_ready) break;
            guard++;
            if (guard > 200) begin
                check("in_stall", 0, 1);
                break;
            end
            @(negedge clk);
        end
        last_acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic send_frame(input logic [15:0] w[$], input bit first_fast);
        int c0;
        model_frame(w);
        c0 = cyc;
        send_word(w[0], first_fast ? 0 : $urandom_range(0, 2));
        if (first_fast) check("first_acc_after_reset", last_acc_cyc, c0);
        for (int i = 1; i < w.size(); i++) send_word(w[i], $urandom_range(0, 2));
    endtask

    // Output monitor with random sink backpressure (never more than 3 low cycles in a row).
    initial begin
        int          lo_run;
        logic [16:0] ed;
        logic [39:0] eh;
        logic        ec;
        lo_run    = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (lo_run >= 3) out_ready = 1'b1;
            else             out_ready = 1'($urandom_range(0, 1));
            lo_run = out_ready ? 0 : lo_run + 1;
            #4;
            if (!reset) begin
                if (out_valid && out_ready) begin
                    if (exp_dat.size() == 0) check("unexpected_out_word", out_data, 17'h1ffff);
                    else begin
                        ed = exp_dat.pop_front();
                        check("out_word", {out_last, out_data}, ed);
                    end
                end
                if (hdr_valid) begin
                    if (exp_hdr.size() == 0) check("unexpected_hdr", 1, 0);
                    else begin
                        eh = exp_hdr.pop_front();
                        check("hdr", {dest, cmd, length}, eh);
                    end
                end
                if (frame_done) begin
                    if (exp_done.size() == 0) check("unexpected_frame_done", 1, 0);
                    else begin
                        ec = exp_done.pop_front();
                        check("csum_ok", csum_ok, ec);
                    end
                end
                if (timeout_err) begin
                    if (exp_tmo == 0) check("unexpected_timeout", 1, 0);
                    else begin
                        exp_tmo--;
                        check("timeout_latency", cyc - last_acc_cyc, 17);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [15:0] fw[$];
        int          guard;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        fw = {16'h0001, 16'h0020, 16'h0000, 16'h0002, 16'h0061, 16'h0099, 16'h0000, 16'h00FA};
        send_frame(fw, 1);
        fw = {16'h0001, 16'h0020, 16'h0000, 16'h0002, 16'h0061, 16'h0099, 16'h0000, 16'h00FB};
        send_frame(fw, 0);
        fw = {16'h0001, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        send_frame(fw, 0);

        for (int f = 0; f < 20; f++) begin
            make_frame(16'($urandom), 16'($urandom), $urandom_range(0, 8), 0,
                       ($urandom_range(0, 3) == 0), fw);
            send_frame(fw, 0);
        end

        make_frame(16'h0003, 16'h0020, 512, 1, 0, fw);
        send_frame(fw, 0);

        // Host goes silent after the second payload word of a length-4 frame.
        make_frame(16'h0005, 16'h0030, 4, 0, 0, fw);
        exp_hdr.push_back({fw[0][7:0], fw[1][7:0], fw[2][7:0], fw[3]});
        exp_dat.push_back({1'b0, fw[4]});
        exp_dat.push_back({1'b0, fw[5]});
        exp_tmo++;
        for (int i = 0; i < 6; i++) send_word(fw[i], $urandom_range(0, 2));
        guard = 0;
        while (exp_tmo != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        check("timeout_seen", exp_tmo, 0);
        make_frame(16'h0006, 16'h0010, 3, 0, 0, fw);
        send_frame(fw, 0);

        // Reset while the parser sits in the payload phase.
        make_frame(16'h0007, 16'h0020, 6, 0, 0, fw);
        exp_hdr.push_back({fw[0][7:0], fw[1][7:0], fw[2][7:0], fw[3]});
        exp_dat.push_back({1'b0, fw[4]});
        exp_dat.push_back({1'b0, fw[5]});
        for (int i = 0; i < 6; i++) send_word(fw[i], $urandom_range(0, 2));
        repeat (8) @(negedge clk);
        check("pre_reset_drain", exp_dat.size(), 0);
        reset = 1'b1;
        exp_dat.delete();
        repeat (2) @(negedge clk);
        check_idle("midframe_reset");
        reset = 1'b0;
        make_frame(16'h0008, 16'h0040, 5, 0, 0, fw);
        send_frame(fw, 1);

        guard = 0;
        while ((exp_dat.size() != 0 || exp_hdr.size() != 0 || exp_done.size() != 0 || exp_tmo != 0)
               && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
        check("left_out_words", exp_dat.size(), 0);
        check("left_hdrs", exp_hdr.size(), 0);
        check("left_frame_done", exp_done.size(), 0);
        check("left_timeouts", exp_tmo, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
